// File: rtl/mult_pkg.sv
// Shared types and default operand widths for the mult_low issue stage.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feeder_state_t;

    localparam int MULT_N_DEFAULT = 8;
    localparam int MULT_M_DEFAULT = 4;

endpackage

// File: rtl/mult_low_feeder_if.sv
// Operand stream, multiplier handshake and product stream of mult_low_feeder.
interface mult_low_feeder_if
    import mult_pkg::*;
#(
    parameter int N     = MULT_N_DEFAULT,
    parameter int M     = MULT_M_DEFAULT,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_mult1;
    logic [M-1:0]     in_mult2;
    logic             mul_data_rdy;
    logic [N-1:0]     mul_mult1;
    logic [M-1:0]     mul_mult2;
    logic             mul_res_rdy;
    logic [M+N-1:0]   mul_res;
    logic             out_valid;
    logic             out_ready;
    logic [M+N-1:0]   out_res;
    logic             busy;
    logic             err;
    logic [CW-1:0]    fifo_count;

    // master is the feeder itself; slave is the producer/multiplier/consumer side
    modport master (
        input  in_valid, in_mult1, in_mult2, mul_res_rdy, mul_res, out_ready,
        output in_ready, mul_data_rdy, mul_mult1, mul_mult2,
               out_valid, out_res, busy, err, fifo_count
    );

    modport slave (
        output in_valid, in_mult1, in_mult2, mul_res_rdy, mul_res, out_ready,
        input  in_ready, mul_data_rdy, mul_mult1, mul_mult2,
               out_valid, out_res, busy, err, fifo_count
    );

endinterface

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO holding packed {mult1, mult2} operand pairs.
module mult_op_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mult_low_feeder.sv
// Issue stage for the non-pipelined mult_low: buffers operand pairs, issues one at
// a time with a data_rdy pulse, and holds each product in a valid/ready output slot.
module mult_low_feeder
    import mult_pkg::*;
#(
    parameter int N       = MULT_N_DEFAULT,
    parameter int M       = MULT_M_DEFAULT,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rstn,
    mult_low_feeder_if.master bus
);
    localparam int PW = M + N;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    feeder_state_t  state_q, state_d;
    logic [N-1:0]   mult1_q, mult1_d;
    logic [M-1:0]   mult2_q, mult2_d;
    logic           data_rdy_q, data_rdy_d;
    logic           out_valid_q, out_valid_d;
    logic [PW-1:0]  out_res_q, out_res_d;
    logic           err_q, err_d;
    logic [TW-1:0]  cnt_q, cnt_d;

    logic [PW-1:0]  fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_cnt;
    logic           slot_free;
    logic           start;

    mult_op_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.in_valid),
        .wdata ({bus.in_mult1, bus.in_mult2}),
        .pop   (start),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // Issuing only into a free output slot guarantees the capture in WAIT never
    // overwrites an unconsumed product.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign start     = (state_q == IDLE) && !fifo_empty && !bus.mul_res_rdy && slot_free;

    always_comb begin
        state_d     = state_q;
        mult1_d     = mult1_q;
        mult2_d     = mult2_q;
        data_rdy_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    mult1_d    = fifo_rdata[PW-1:M];
                    mult2_d    = fifo_rdata[M-1:0];
                    data_rdy_d = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.mul_res_rdy) begin
                    out_res_d   = bus.mul_res;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mult1_q     <= '0;
            mult2_q     <= '0;
            data_rdy_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mult1_q     <= mult1_d;
            mult2_q     <= mult2_d;
            data_rdy_q  <= data_rdy_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready     = !fifo_full;
    assign bus.mul_data_rdy = data_rdy_q;
    assign bus.mul_mult1    = mult1_q;
    assign bus.mul_mult2    = mult2_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_res      = out_res_q;
    assign bus.err          = err_q;
    assign bus.busy         = (state_q != IDLE) || !fifo_empty;
    assign bus.fifo_count   = fifo_cnt;

endmodule

// File: tb/tb_mult_low_feeder.sv
// Directed bench for mult_low_feeder with a behavioural mult_low stub and a product scoreboard.
module tb_mult_low_feeder;
    import mult_pkg::*;

    localparam int N       = 8;
    localparam int M       = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int PW      = N + M;
    localparam int MUL_LAT = M;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mult_low_feeder_if #(.N(N), .M(M), .DEPTH(DEPTH)) bus ();

    mult_low_feeder #(.N(N), .M(M), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] sb [$];
    int   pulses  = 0;
    logic prev_dr = 1'b0;

    // mult_low stub: latches operands on data_rdy, answers MUL_LAT cycles later and
    // holds res_rdy for two cycles; `stuck` suppresses the answer entirely.
    logic [N-1:0]  m_a = '0;
    logic [M-1:0]  m_b = '0;
    logic [PW-1:0] m_res = '0;
    int   lat  = 0;
    int   hold = 0;
    logic rr = 1'b0;
    logic rr_force = 1'b0;
    logic stuck = 1'b0;

    assign bus.mul_res_rdy = rr | rr_force;
    assign bus.mul_res     = m_res;

    always @(posedge clk) begin
        if (bus.mul_data_rdy) begin
            m_a <= bus.mul_mult1;
            m_b <= bus.mul_mult2;
            lat <= MUL_LAT;
        end else if (lat > 1) begin
            lat <= lat - 1;
        end else if (lat == 1) begin
            lat <= 0;
            if (!stuck) begin
                m_res <= m_a * m_b;
                rr    <= 1'b1;
                hold  <= 2;
            end
        end else if (hold > 1) begin
            hold <= hold - 1;
        end else if (hold == 1) begin
            hold <= 0;
            rr   <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (bus.mul_data_rdy) begin
                pulses++;
                $display("issue %0d x %0d", bus.mul_mult1, bus.mul_mult2);
                check("issue_res_rdy_low", {31'd0, bus.mul_res_rdy}, 32'd0);
                check("issue_single_cycle", {31'd0, prev_dr}, 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                $display("product %0d", bus.out_res);
                check("product_expected", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    logic [PW-1:0] exp_res;
                    exp_res = sb.pop_front();
                    check("product_value", 32'(bus.out_res), 32'(exp_res));
                end
            end
        end
        prev_dr = bus.mul_data_rdy;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [M-1:0] b, input bit expect_out);
        logic [PW-1:0] prod;
        bit accepted;
        accepted     = 1'b0;
        prod         = a * b;
        bus.in_valid = 1'b1;
        bus.in_mult1 = a;
        bus.in_mult2 = b;
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.in_ready;
            if (accepted && expect_out) sb.push_back(prod);
            align();
        end
        bus.in_valid = 1'b0;
        if (accepted) $display("push %0d x %0d", a, b);
        check("push_accepted", {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_out(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_dr(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mul_data_rdy;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = !bus.busy && !bus.out_valid && sb.size() == 0 && lat == 0 && hold == 0;
        end
        check(tag, {31'd0, done}, 32'd1);
        align();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_count"},     32'(bus.fifo_count), 32'd0);
        check({tag, "_data_rdy"},  {31'd0, bus.mul_data_rdy}, 32'd0);
        check({tag, "_mult1"},     32'(bus.mul_mult1), 32'd0);
        check({tag, "_mult2"},     32'(bus.mul_mult2), 32'd0);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_out_res"},   32'(bus.out_res), 32'd0);
        check({tag, "_err"},       {31'd0, bus.err}, 32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int tcyc;
        logic ov;

        bus.in_valid  = 1'b0;
        bus.in_mult1  = '0;
        bus.in_mult2  = '0;
        bus.out_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rstn = 1'b1;
        align();

        // Single pair
        p0 = pulses;
        push(8'd25, 4'd5, 1'b1);
        wait_out("single_out_seen");
        check("single_out_res", 32'(bus.out_res), 32'd125);
        @(negedge clk);
        check("single_out_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        wait_quiet("single_drain");
        check("single_pulses", 32'(pulses - p0), 32'd1);

        // Burst of five, issue held off so the FIFO fills
        p0 = pulses;
        rr_force = 1'b1;
        push(8'd25, 4'd5, 1'b1);
        push(8'd16, 4'd10, 1'b1);
        push(8'd10, 4'd4, 1'b1);
        push(8'd15, 4'd7, 1'b1);
        check("burst_full_count", 32'(bus.fifo_count), 32'd4);
        check("burst_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("burst_busy", {31'd0, bus.busy}, 32'd1);
        rr_force = 1'b0;
        push(8'd215, 4'd9, 1'b1);
        wait_quiet("burst_drain");
        check("burst_pulses", 32'(pulses - p0), 32'd5);

        // Output backpressure stalls the next issue
        p0 = pulses;
        bus.out_ready = 1'b0;
        push(8'd25, 4'd5, 1'b1);
        push(8'd16, 4'd10, 1'b1);
        wait_out("bp_out_seen");
        repeat (20) @(negedge clk);
        check("bp_pulses_stalled", 32'(pulses - p0), 32'd1);
        check("bp_out_valid_held", {31'd0, bus.out_valid}, 32'd1);
        check("bp_out_res_held", 32'(bus.out_res), 32'd125);
        check("bp_count", 32'(bus.fifo_count), 32'd1);
        align();
        bus.out_ready = 1'b1;
        wait_quiet("bp_drain");
        check("bp_pulses", 32'(pulses - p0), 32'd2);

        // Timeout with the multiplier never answering
        stuck = 1'b1;
        push(8'd15, 4'd7, 1'b0);
        wait_dr("to_issue_seen");
        tcyc = -1;
        for (int k = 0; k < 200 && tcyc < 0; k++) begin
            @(negedge clk);
            if (bus.err) tcyc = k;
        end
        check("to_err_cycles", 32'(tcyc), 32'(TIMEOUT));
        check("to_idle", {31'd0, bus.busy}, 32'd0);
        stuck = 1'b0;
        align();
        push(8'd10, 4'd4, 1'b1);
        wait_quiet("to_next_drain");
        check("to_err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset while a pair is in flight and two are queued
        push(8'd15, 4'd7, 1'b0);
        push(8'd25, 4'd5, 1'b0);
        push(8'd16, 4'd10, 1'b0);
        check("rst_pre_count", 32'(bus.fifo_count), 32'd2);
        check("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        p0 = pulses;
        ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) rr_force = 1'b1;
            if (i == 11) rr_force = 1'b0;
            @(negedge clk);
            ov = ov | bus.out_valid;
        end
        check("rst_no_out", {31'd0, ov}, 32'd0);
        check("rst_no_issue", 32'(pulses - p0), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        align();

        // Push concurrent with the IDLE->ISSUE pop
        rr_force = 1'b1;
        push(8'd10, 4'd4, 1'b1);
        push(8'd15, 4'd7, 1'b1);
        check("pp_pre_count", 32'(bus.fifo_count), 32'd2);
        rr_force = 1'b0;
        push(8'd215, 4'd9, 1'b1);
        check("pp_count_same", 32'(bus.fifo_count), 32'd2);
        check("pp_issue", {31'd0, bus.mul_data_rdy}, 32'd1);
        check("pp_issue_mult1", 32'(bus.mul_mult1), 32'd10);
        wait_quiet("pp_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
